elink_word_packer: RTL and testbench



---
 rtl/elink_word_packer_pkg.sv | 25 ++
 rtl/elink_word_packer_if.sv | 11 +
 rtl/elink_word_packer.sv | 97 +++++++++
 tb/tb_elink_word_packer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/elink_word_packer_pkg.sv
// Shared e-link packer types: byte/word widths, byte-index enum and the registered state record.
package elink_pkg;

    localparam int ELINK_BYTE_W         = 8;
    localparam int ELINK_WORD_W         = 32;
    localparam int ELINK_BYTES_PER_WORD = 4;
    localparam int ELINK_MAX_LINKS      = 32;
    localparam int ELINK_ASM_W          = ELINK_WORD_W - ELINK_BYTE_W;

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } byte_idx_e;

    // Sized for the widest build; lanes above N_LINKS stay at their reset value.
    typedef struct packed {
        byte_idx_e                                    idx;
        logic [ELINK_MAX_LINKS-1:0][ELINK_ASM_W-1:0]  asm_data;
        logic [ELINK_MAX_LINKS-1:0][ELINK_WORD_W-1:0] out_data;
        logic                                         out_vld;
    } packer_state_t;

endpackage

// File: rtl/elink_word_packer_if.sv
// Single-handshake stream bundle shared by the byte side and the word side of the packer.
interface elink_word_packer_if #(
    parameter int W = elink_pkg::ELINK_BYTE_W
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/elink_word_packer.sv
// Packs N_LINKS byte lanes MSB-first into 32-bit words behind one shared handshake.
// Optional counters (words_out, partial_drops) are built when ELINK_PACKER_STATS_EN is defined.
module elink_word_packer
    import elink_pkg::*;
#(
    parameter int N_LINKS = 1
) (
    input  logic                  clk160,
    input  logic                  clk160_aresetn,
    elink_word_packer_if.slave    S_AXIS,
    input  logic                  realign,
    elink_word_packer_if.master   M_AXIS
`ifdef ELINK_PACKER_STATS_EN
    ,
    output logic [31:0]           words_out,
    output logic [15:0]           partial_drops
`endif
);

    packer_state_t                      st_q;
    packer_state_t                      st_d;
    byte_idx_e                          wr_idx;
    logic                               s_ready;
    logic                               accept;
    logic [N_LINKS*ELINK_WORD_W-1:0]    m_data;

    // A completing byte may only be taken if the output slot is free or draining now.
    assign s_ready = !(st_q.idx == BYTE3 && st_q.out_vld && !M_AXIS.tready);
    assign accept  = S_AXIS.tvalid && s_ready;

    always_comb begin
        st_d   = st_q;
        wr_idx = realign ? BYTE0 : st_q.idx;

        if (M_AXIS.tready) begin
            st_d.out_vld = 1'b0;
        end

        if (realign) begin
            st_d.idx      = BYTE0;
            st_d.asm_data = '0;
        end

        if (accept) begin
            if (wr_idx != BYTE3) begin
                for (int i = 0; i < N_LINKS; i++) begin
                    st_d.asm_data[i][(ELINK_ASM_W - ELINK_BYTE_W) - ELINK_BYTE_W*int'(wr_idx) +: ELINK_BYTE_W] =
                        S_AXIS.tdata[ELINK_BYTE_W*i +: ELINK_BYTE_W];
                end
                st_d.idx = byte_idx_e'(wr_idx + 2'd1);
            end else begin
                for (int i = 0; i < N_LINKS; i++) begin
                    st_d.out_data[i] = {st_q.asm_data[i], S_AXIS.tdata[ELINK_BYTE_W*i +: ELINK_BYTE_W]};
                end
                st_d.out_vld = 1'b1;
                st_d.idx     = BYTE0;
            end
        end
    end

    always_ff @(posedge clk160 or negedge clk160_aresetn) begin
        if (!clk160_aresetn) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < N_LINKS; i++) begin
            m_data[ELINK_WORD_W*i +: ELINK_WORD_W] = st_q.out_data[i];
        end
    end

    assign S_AXIS.tready = s_ready;
    assign M_AXIS.tdata  = m_data;
    assign M_AXIS.tvalid = st_q.out_vld;

`ifdef ELINK_PACKER_STATS_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clk160 or negedge clk160_aresetn) begin
        if (!clk160_aresetn) begin
            words_out     <= '0;
            partial_drops <= '0;
        end else begin
            if (st_q.out_vld && M_AXIS.tready && words_out != '1) begin
                words_out <= words_out + 32'd1;
            end
            if (realign && st_q.idx != BYTE0 && partial_drops != '1) begin
                partial_drops <= partial_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_elink_word_packer.sv
// Directed and randomised bench for elink_word_packer (N_LINKS=2) against a byte-queue reference model.
module tb_elink_word_packer;
    import elink_pkg::*;

    localparam int N = 2;

    logic clk160 = 1'b0;
    logic rst_n  = 1'b0;
    logic realign = 1'b0;

    elink_word_packer_if #(.W(8*N))  s_if ();
    elink_word_packer_if #(.W(32*N)) m_if ();

`ifdef ELINK_PACKER_STATS_EN
    logic [31:0] words_out;
    logic [15:0] partial_drops;
`endif

    elink_word_packer #(.N_LINKS(N)) dut (
        .clk160         (clk160),
        .clk160_aresetn (rst_n),
        .S_AXIS         (s_if),
        .realign        (realign),
        .M_AXIS         (m_if)
`ifdef ELINK_PACKER_STATS_EN
        ,
        .words_out      (words_out),
        .partial_drops  (partial_drops)
`endif
    );

    always #5 clk160 = ~clk160;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes collected per lane since the last word/realign.
    logic [7:0]  bq [N][$];
    logic        pend;
    logic [63:0] pend_word;
    int          hs_cnt;
    int          drop_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pend      = 1'b0;
        pend_word = '0;
        hs_cnt    = 0;
        drop_cnt  = 0;
        for (int l = 0; l < N; l++) bq[l].delete();
    endtask

    // Called at a negedge: drive, compare against the model, advance the model, wait one cycle.
    task automatic step(input logic sv, input logic [15:0] sd, input logic mr, input logic ra);
        logic        exp_rdy;
        logic        acc;
        logic [63:0] w;
        s_if.tvalid  = sv;
        s_if.tdata   = sd;
        m_if.tready  = mr;
        realign      = ra;
        #1;
        exp_rdy = !(bq[0].size() == 3 && pend && !mr);
        chk("s_tready", {63'd0, s_if.tready}, {63'd0, exp_rdy});
        chk("m_tvalid", {63'd0, m_if.tvalid}, {63'd0, pend});
        if (pend) chk("m_tdata", m_if.tdata, pend_word);
        acc = sv && exp_rdy;
        if (pend && mr) begin
            hs_cnt++;
            pend = 1'b0;
        end
        if (ra) begin
            if (bq[0].size() != 0) drop_cnt++;
            for (int l = 0; l < N; l++) bq[l].delete();
        end
        if (acc) begin
            for (int l = 0; l < N; l++) bq[l].push_back(sd[8*l +: 8]);
            if (bq[0].size() == 4) begin
                w = '0;
                for (int l = 0; l < N; l++) begin
                    w[32*l +: 32] = {bq[l][0], bq[l][1], bq[l][2], bq[l][3]};
                    bq[l].delete();
                end
                pend_word = w;
                pend      = 1'b1;
            end
        end
        @(negedge clk160);
    endtask

    initial begin
        int start;
        int cyc;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        model_reset();

        #12;
        chk("rst_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        chk("rst_tdata",  m_if.tdata, 64'd0);
        chk("rst_tready", {63'd0, s_if.tready}, 64'd1);
        @(negedge clk160);
        rst_n = 1'b1;
        @(negedge clk160);

        // Continuous stream, no backpressure
        step(1'b1, 16'hA1_11, 1'b1, 1'b0);
        step(1'b1, 16'hB2_22, 1'b1, 1'b0);
        step(1'b1, 16'hC3_33, 1'b1, 1'b0);
        step(1'b1, 16'hD4_44, 1'b1, 1'b0);
        chk("t1_vld",  {63'd0, m_if.tvalid}, 64'd1);
        chk("t1_word", m_if.tdata, 64'hA1B2C3D4_11223344);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: next word stalls in BYTE3
        step(1'b1, 16'h01_11, 1'b0, 1'b0);
        step(1'b1, 16'h02_22, 1'b0, 1'b0);
        step(1'b1, 16'h03_33, 1'b0, 1'b0);
        step(1'b1, 16'h04_44, 1'b0, 1'b0);
        step(1'b1, 16'h05_55, 1'b0, 1'b0);
        step(1'b1, 16'h06_66, 1'b0, 1'b0);
        step(1'b1, 16'h07_77, 1'b0, 1'b0);
        step(1'b1, 16'h08_88, 1'b0, 1'b0);
        chk("t2_rdy_low", {63'd0, s_if.tready}, 64'd0);
        chk("t2_hold",    {32'd0, m_if.tdata[31:0]}, 64'h11223344);
        step(1'b1, 16'h08_88, 1'b0, 1'b0);
        step(1'b1, 16'h08_88, 1'b1, 1'b0);
        chk("t2_word", {32'd0, m_if.tdata[31:0]}, 64'h55667788);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Realign discards a partial word
        step(1'b1, 16'hBE_DE, 1'b1, 1'b0);
        step(1'b1, 16'hEF_AD, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        step(1'b1, 16'h10_01, 1'b1, 1'b0);
        step(1'b1, 16'h20_02, 1'b1, 1'b0);
        step(1'b1, 16'h30_03, 1'b1, 1'b0);
        step(1'b1, 16'h40_04, 1'b1, 1'b0);
        chk("t3_word", {32'd0, m_if.tdata[31:0]}, 64'h01020304);
`ifdef ELINK_PACKER_STATS_EN
        chk("t3_drops", {48'd0, partial_drops}, 64'd1);
`endif
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Realign coincident with an accepted byte
        step(1'b1, 16'h12_9A, 1'b1, 1'b1);
        step(1'b1, 16'h34_BC, 1'b1, 1'b0);
        step(1'b1, 16'h56_DE, 1'b1, 1'b0);
        step(1'b1, 16'h78_F0, 1'b1, 1'b0);
        chk("t4_word", m_if.tdata, 64'h12345678_9ABCDEF0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset with a stalled word and a partial word in flight
        step(1'b1, 16'h11_11, 1'b0, 1'b0);
        step(1'b1, 16'h22_22, 1'b0, 1'b0);
        step(1'b1, 16'h33_33, 1'b0, 1'b0);
        step(1'b1, 16'h44_44, 1'b0, 1'b0);
        step(1'b1, 16'h55_55, 1'b0, 1'b0);
        step(1'b1, 16'h66_66, 1'b0, 1'b0);
        step(1'b1, 16'h77_77, 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld",  {63'd0, m_if.tvalid}, 64'd0);
        chk("t5_rst_data", m_if.tdata, 64'd0);
        model_reset();
        @(negedge clk160);
        rst_n = 1'b1;
        @(negedge clk160);
        step(1'b1, 16'hDE_CA, 1'b1, 1'b0);
        step(1'b1, 16'hAD_FE, 1'b1, 1'b0);
        step(1'b1, 16'hBE_BA, 1'b1, 1'b0);
        step(1'b1, 16'hEF_BE, 1'b1, 1'b0);
        chk("t5_word", m_if.tdata, 64'hDEADBEEF_CAFEBABE);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomised handshakes with occasional realign
        start = hs_cnt;
        cyc   = 0;
        while (hs_cnt - start < 1000 && cyc < 40000) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
            cyc++;
        end
        chk("rand_words", 64'(hs_cnt - start), 64'd1000);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef ELINK_PACKER_STATS_EN
        chk("words_out",     {32'd0, words_out},     64'(hs_cnt));
        chk("partial_drops", {48'd0, partial_drops}, 64'(drop_cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
